// File: rtl/sigma_uart_pkg.sv
// Shared UART receiver types: FSM state encoding and the default bit divider.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package sigma_uart_pkg;

    localparam int DEFAULT_BIT_DIV = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) ff_q <= 2'b11;
        else           ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, frame and overrun error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and parity_err_o.
module uart_rx
    import sigma_uart_pkg::*;
#(
    parameter int BIT_DIV = DEFAULT_BIT_DIV
) (
    input  logic       clk_i,
    input  logic       arst_n_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       parity_err_o
);

    localparam int CW = $clog2(BIT_DIV);
    localparam logic [CW-1:0] HALF = CW'(BIT_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BIT_DIV - 1);

    logic rx_s;

    uart_rx_sync u_sync (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .d_i      (rx_i),
        .q_o      (rx_s)
    );

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          tick, deliver;
`ifdef UART_RX_PARITY_EN
    logic          perr_q, perr_d;
    logic          pbad_q, pbad_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = 1'b0;
        pbad_d  = pbad_q;
`endif
        tick = (cnt_q == '0);
        // Saturating down-counter; each state reloads it when it consumes a tick.
        if (!tick) cnt_d = cnt_q - CW'(1);

        case (state_q)
            IDLE: if (!rx_s) begin
                cnt_d   = HALF;
                state_d = START;
`ifdef UART_RX_PARITY_EN
                pbad_d  = 1'b0;
`endif
            end
            START: if (tick) begin
                if (!rx_s) begin
                    cnt_d   = FULL;
                    idx_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: if (tick) begin
                shift_d[idx_q] = rx_s;
                cnt_d          = FULL;
                idx_d          = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (idx_q == 3'd7) state_d = PARITY;
`else
                if (idx_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (tick) begin
                // Even parity: data bits plus parity bit must XOR to zero.
                pbad_d  = (^shift_q) ^ rx_s;
                perr_d  = pbad_d;
                cnt_d   = FULL;
                state_d = STOP;
            end
`endif
            STOP: if (tick) begin
                if (rx_s) begin
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    deliver = !pbad_q;
`else
                    deliver = 1'b1;
`endif
                end else begin
                    ferr_d  = 1'b1;
                    state_d = BREAK;
                end
            end
            BREAK: if (rx_s) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (valid_q && ready_i) valid_d = 1'b0;
        // A byte landing while the held one is not being taken is dropped.
        if (deliver) begin
            if (valid_q && !ready_i) begin
                ovr_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
            pbad_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_d;
            pbad_q  <= pbad_d;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at BIT_DIV=16; expected bytes queued by stimulus, popped by monitor.
module tb_uart_rx;

    localparam int BD = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    // 2 sync + 1 idle detect + 8 half-bit + 9 x 16 data/stop = stop sample 155 edges after start.
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       arst_n, rx, ready;
    logic [7:0] data;
    logic       valid, ferr, ovr, perr;

    uart_rx #(.BIT_DIV(BD)) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .rx_i         (rx),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .frame_err_o  (ferr),
        .overrun_o    (ovr),
        .parity_err_o (perr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         total = 0, bad = 0;
    logic [7:0] exp_q[$];
    int         n_ferr = 0, n_ovr = 0, n_perr = 0, n_xfer = 0;
    int         start_cyc = 0;
    logic       lat_en = 1'b0;
    logic       valid_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pulse counting, first-valid latency, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (ferr) n_ferr++;
        if (ovr)  n_ovr++;
        if (perr) n_perr++;
        if (valid && !valid_prev && lat_en) begin
            chk("latency", cyc - start_cyc, LAT);
            lat_en = 1'b0;
        end
        valid_prev = valid;
        if (valid && ready) begin
            n_xfer++;
            if (exp_q.size() == 0) chk("unexpected_byte", int'(data), -1);
            else                   chk("data", int'(data), int'(exp_q.pop_front()));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input logic par_flip);
        rx = 1'b0;
        tick(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BD);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(BD);
`else
        if (par_flip) rx = 1'b0;
`endif
        rx = stop_v;
        tick(BD);
        rx = 1'b1;
    endtask

    initial begin
        arst_n = 1'b0;
        rx     = 1'b1;
        ready  = 1'b1;
        tick(3);
        chk("rst_valid", int'(valid), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ferr", int'(ferr), 0);
        chk("rst_ovr", int'(ovr), 0);
        arst_n = 1'b1;
        tick(5);

        // Plain byte with latency check
        exp_q.push_back(8'hA5);
        start_cyc = cyc;
        lat_en    = 1'b1;
        send(8'hA5, 1'b1, 1'b0);
        tick(BD);
        chk("a5_xfer", n_xfer, 1);
        chk("a5_ferr", n_ferr, 0);
        chk("a5_ovr", n_ovr, 0);
        chk("a5_lat_seen", int'(lat_en), 0);

        // Short glitch must not start a frame
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(3 * BD);
        chk("glitch_noxfer", n_xfer, 1);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1, 1'b0);
        tick(BD);
        chk("5a_xfer", n_xfer, 2);

        // Bad stop bit, line held low, then recovery
        send(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(BD);
        chk("frame_err_cnt", n_ferr, 1);
        chk("3c_noxfer", n_xfer, 2);
        exp_q.push_back(8'hC3);
        send(8'hC3, 1'b1, 1'b0);
        tick(BD);
        chk("c3_xfer", n_xfer, 3);
        chk("c3_data_after", int'(data), 8'hC3);

        // Overrun while consumer stalls
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, 1'b0);
        tick(BD);
        send(8'h22, 1'b1, 1'b0);
        tick(BD);
        chk("ovr_cnt", n_ovr, 1);
        chk("ovr_hold_data", int'(data), 8'h11);
        chk("ovr_hold_valid", int'(valid), 1);
        ready = 1'b1;
        tick(1);
        chk("valid_drop", int'(valid), 0);
        chk("11_xfer", n_xfer, 4);

        // Reset mid-frame during bit 4 of 0xFF
        rx = 1'b0;
        tick(BD);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            tick(BD);
        end
        tick(BD / 2);
        arst_n = 1'b0;
        #1;
        chk("midrst_data", int'(data), 0);
        chk("midrst_valid", int'(valid), 0);
        rx = 1'b1;
        tick(3);
        arst_n = 1'b1;
        tick(2 * BD);
        exp_q.push_back(8'h80);
        send(8'h80, 1'b1, 1'b0);
        tick(BD);
        chk("80_xfer", n_xfer, 5);
        chk("80_data", int'(data), 8'h80);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send(8'h07, 1'b1, 1'b0);
        tick(BD);
        chk("par_good_xfer", n_xfer, 6);
        send(8'h07, 1'b1, 1'b1);
        tick(BD);
        chk("par_bad_noxfer", n_xfer, 6);
        chk("par_err_cnt", n_perr, 1);
`else
        chk("par_err_cnt", n_perr, 0);
`endif
        chk("frame_err_total", n_ferr, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BIT_DIV, default 868, clk_i cycles per bit (115200 baud at 100 MHz); legal range 8..65535.
REQ-002 SHALL have port clk_i  input  1  system clock; all state on its rising edge.
REQ-003 SHALL have port arst_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rx_i  input  1  asynchronous serial line; idle high, 8N1 (8E1 with macro), LSB first.
REQ-005 SHALL have port data_o  output  8  received byte; valid only while valid_o=1.
REQ-006 SHALL have port valid_o  output  1  byte available.
REQ-007 SHALL have port ready_i  input  1  consumer accepts; transfer when valid_o&&ready_i.
REQ-008 SHALL have port frame_err_o  output  1  one-cycle pulse on bad stop bit.
REQ-009 SHALL have port overrun_o  output  1  one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port parity_err_o  output  1  one-cycle pulse on parity mismatch (constant 0 without macro).

Function
REQ-011 rx_i SHALL pass a 2-flop synchronizer reset to 1; FSM sees only synchronized rx_s.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-013 IDLE: rx_s==0 -> load bit counter BIT_DIV/2-1, go START.
REQ-014 START: on counter==0, rx_s==0 -> counter=BIT_DIV-1, bit index 0, go DATA; rx_s==1 -> glitch, go IDLE, no output.
REQ-015 DATA: each counter==0 SHALL shift rx_s into bit[index], reload BIT_DIV-1; after index 7 go PARITY (macro) or STOP.
REQ-016 STOP: on counter==0, rx_s==1 -> deliver byte, go IDLE; rx_s==0 -> frame_err_o pulse, byte discarded, go BREAK.
REQ-017 BREAK: stay until rx_s==1, then IDLE; no new start detected while in BREAK.
REQ-018 Deliver SHALL assert valid_o and update data_o on the cycle after the stop-bit sample.
REQ-019 valid_o/data_o SHALL be held stable until valid_o&&ready_i; then valid_o drops next cycle unless a deliver coincides.
REQ-020 Deliver with valid_o=1 and ready_i=1 in the same cycle: new byte SHALL load, valid_o stays 1, no overrun.
REQ-021 Deliver with valid_o=1 and ready_i=0: new byte dropped, held byte unchanged, overrun_o pulses one cycle.
REQ-022 Counter SHALL be $clog2(BIT_DIV) bits wide, decrementing, never wrapping below 0.

Reset
REQ-023 arst_n_i low SHALL immediately force IDLE, synchronizer=1, counter=0, data_o=0, valid_o=0, all error pulses 0.
REQ-024 Reset mid-frame SHALL discard the partial byte; after release, receiver waits for a new falling edge in IDLE.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined: PARITY state SHALL sample one even-parity bit after data; mismatch -> parity_err_o pulse, byte discarded, proceed to STOP normally (frame_err still checked).
REQ-026 Macro undefined: PARITY state SHALL be absent, DATA goes straight to STOP, parity_err_o tied 0.

Structure
REQ-027 State enum and default BIT_DIV constant SHALL live in package sigma_uart_pkg.
REQ-028 Synchronizer SHALL be sub-module uart_rx_sync (2 flops, async reset to 1).

Verification (bench BIT_DIV=16)
REQ-029 Send 0xA5, ready_i=1 -> one valid_o cycle with data_o=0xA5, 1 clk after stop sample; no error pulses.
REQ-030 rx_i low for 4 clk then high -> no valid_o, FSM back in IDLE; following 0x5A received correctly.
REQ-031 Send 0x3C with stop bit 0, hold line low 40 clk, then 0xC3 -> one frame_err_o pulse, no valid for 0x3C, data_o=0xC3 after.
REQ-032 ready_i=0, send 0x11 then 0x22 -> data_o stays 0x11, one overrun_o pulse at second stop; ready_i=1 -> 0x11 consumed, valid_o drops.
REQ-033 Assert arst_n_i during bit 4 of 0xFF -> outputs zero immediately; after release send 0x80 -> data_o=0x80.
REQ-034 With UART_RX_PARITY_EN: 0x07 with parity 1 -> valid 0x07; 0x07 with parity 0 -> parity_err_o pulse, no valid_o.
